exp7_unidade_controle: RTL and testbench

//  Game-sequencing FSM for the memory game. Each round it replays the stored sequence on the LEDs
//  (addresses 0..rodada), then collects player moves with a timeout and compares them against memory.
//  It drives the datapath counter/register controls (endereco E, rodada Rod, timeout T, jogada R).
//  An internal timer sets how long each LED is lit and the gap between steps.
//

---
 rtl/exp7_unidade_controle.sv | 199 +++++++++++++++++++
 tb/tb_exp7_unidade_controle.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exp7_unidade_controle.sv
// Memory-game sequencing FSM: replays the stored sequence each round, then collects and
// checks the player's moves, driving the datapath counter/register controls.
module exp7_unidade_controle #(
   parameter int DISP_CYCLES = 1000,
   parameter int GAP_CYCLES  = 250
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       enderecoIgualRodada,
   input  logic       fimRod,
   input  logic       fimT,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraRod,
   output logic       contaRod,
   output logic       zeraT,
   output logic       contaT,
   output logic       zeraR,
   output logic       registraR,
   output logic       mostraLeds,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   // state          | meaning
   // inicial        | idle, waiting for iniciar
   // preparacao     | clear address, round, timeout and move register
   // inicia_rodada  | rewind address for the replay
   // mostra         | LED lit with memory[endereco] for DISP_CYCLES
   // intervalo      | LEDs dark for GAP_CYCLES
   // proximo_mostra | advance to the next replayed step
   // zera_endereco  | replay done, rewind address for the player
   // espera         | waiting for a move, timeout counter running
   // registra       | latch the move
   // compara        | check the move against memory
   // proxima_jogada | advance to the next expected move
   // proxima_rodada | round complete, grow the sequence
   // fim_*          | game over (win / timeout / wrong move)

   localparam int TMAX = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] DISP_LAST = TW'(DISP_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      INICIA_RODADA  = 4'h2,
      MOSTRA         = 4'h3,
      INTERVALO      = 4'h4,
      PROXIMO_MOSTRA = 4'h5,
      ESPERA         = 4'h6,
      REGISTRA       = 4'h7,
      COMPARA        = 4'h8,
      PROXIMA_JOGADA = 4'h9,
      FIM_ACERTOU    = 4'hA,
      PROXIMA_RODADA = 4'hB,
      ZERA_ENDERECO  = 4'hC,
      FIM_TIMEOUT    = 4'hD,
      FIM_ERROU      = 4'hE
   } state_t;

   typedef struct packed {
      logic zera_e;
      logic conta_e;
      logic zera_rod;
      logic conta_rod;
      logic zera_t;
      logic conta_t;
      logic zera_r;
      logic registra_r;
      logic mostra_leds;
      logic pronto;
      logic acertou;
      logic errou;
      logic timeout;
   } ctrl_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   ctrl_t           ctrl_q, ctrl_d;

   always_comb begin
      state_d = state_q;
      timer_d = '0;
      case (state_q)
         INICIAL:        if (iniciar) state_d = PREPARACAO;
         PREPARACAO:     state_d = INICIA_RODADA;
         INICIA_RODADA:  state_d = MOSTRA;
         MOSTRA: begin
            if (timer_q == DISP_LAST) state_d = INTERVALO;
            else                      timer_d = timer_q + TW'(1);
         end
         INTERVALO: begin
            if (timer_q == GAP_LAST)
               state_d = enderecoIgualRodada ? ZERA_ENDERECO : PROXIMO_MOSTRA;
            else
               timer_d = timer_q + TW'(1);
         end
         PROXIMO_MOSTRA: state_d = MOSTRA;
         ZERA_ENDERECO:  state_d = ESPERA;
         ESPERA: begin
            // a move landing on the timeout cycle still counts
            if (jogada)    state_d = REGISTRA;
            else if (fimT) state_d = FIM_TIMEOUT;
         end
         REGISTRA:       state_d = COMPARA;
         COMPARA: begin
            if (!igual)                    state_d = FIM_ERROU;
            else if (!enderecoIgualRodada) state_d = PROXIMA_JOGADA;
            else if (fimRod)               state_d = FIM_ACERTOU;
            else                           state_d = PROXIMA_RODADA;
         end
         PROXIMA_JOGADA: state_d = ESPERA;
         PROXIMA_RODADA: state_d = INICIA_RODADA;
         FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU:
                         if (iniciar) state_d = PREPARACAO;
         default:        state_d = INICIAL;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they always match state_q.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         PREPARACAO: begin
            ctrl_d.zera_e   = 1'b1;
            ctrl_d.zera_rod = 1'b1;
            ctrl_d.zera_t   = 1'b1;
            ctrl_d.zera_r   = 1'b1;
         end
         INICIA_RODADA: begin
            ctrl_d.zera_e = 1'b1;
            ctrl_d.zera_t = 1'b1;
         end
         MOSTRA:         ctrl_d.mostra_leds = 1'b1;
         PROXIMO_MOSTRA: ctrl_d.conta_e     = 1'b1;
         ZERA_ENDERECO: begin
            ctrl_d.zera_e = 1'b1;
            ctrl_d.zera_t = 1'b1;
            ctrl_d.zera_r = 1'b1;
         end
         ESPERA:         ctrl_d.conta_t    = 1'b1;
         REGISTRA:       ctrl_d.registra_r = 1'b1;
         PROXIMA_JOGADA: begin
            ctrl_d.conta_e = 1'b1;
            ctrl_d.zera_t  = 1'b1;
         end
         PROXIMA_RODADA: ctrl_d.conta_rod = 1'b1;
         FIM_ACERTOU: begin
            ctrl_d.pronto  = 1'b1;
            ctrl_d.acertou = 1'b1;
         end
         FIM_TIMEOUT: begin
            ctrl_d.pronto  = 1'b1;
            ctrl_d.timeout = 1'b1;
         end
         FIM_ERROU: begin
            ctrl_d.pronto = 1'b1;
            ctrl_d.errou  = 1'b1;
         end
         default:        ctrl_d = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= INICIAL;
         timer_q <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign zeraE      = ctrl_q.zera_e;
   assign contaE     = ctrl_q.conta_e;
   assign zeraRod    = ctrl_q.zera_rod;
   assign contaRod   = ctrl_q.conta_rod;
   assign zeraT      = ctrl_q.zera_t;
   assign contaT     = ctrl_q.conta_t;
   assign zeraR      = ctrl_q.zera_r;
   assign registraR  = ctrl_q.registra_r;
   assign mostraLeds = ctrl_q.mostra_leds;
   assign pronto     = ctrl_q.pronto;
   assign acertou    = ctrl_q.acertou;
   assign errou      = ctrl_q.errou;
   assign timeout    = ctrl_q.timeout;
   assign db_estado  = state_q;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Bench for exp7_unidade_controle: directed vector table, hand sequences for reset and win,
// then random play against a game-level model that emulates the address/round counters.
module tb_exp7_unidade_controle;
   localparam int DISP = 4;
   localparam int GAP  = 2;
   localparam int LAST_ROUND = 2;

   logic clock = 1'b0;
   logic reset, iniciar, jogada, igual, eir, fimRod, fimT;
   logic zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR;
   logic mostraLeds, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   int n_tests = 0;
   int n_fail  = 0;

   exp7_unidade_controle #(.DISP_CYCLES(DISP), .GAP_CYCLES(GAP)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
      .enderecoIgualRodada(eir), .fimRod(fimRod), .fimT(fimT),
      .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
      .zeraT(zeraT), .contaT(contaT), .zeraR(zeraR), .registraR(registraR),
      .mostraLeds(mostraLeds), .pronto(pronto), .acertou(acertou), .errou(errou),
      .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // {zeraE,contaE,zeraRod,contaRod,zeraT,contaT,zeraR,registraR,mostraLeds,pronto,acertou,errou,timeout}
   function automatic logic [12:0] exp_out(input logic [3:0] c);
      logic ze, ce, zr, cr, zt, ct, zrr, rr, ml, pr, ac, er, to;
      {ze, ce, zr, cr, zt, ct, zrr, rr, ml, pr, ac, er, to} = '0;
      case (c)
         4'h1: begin ze = 1; zr = 1; zt = 1; zrr = 1; end
         4'h2: begin ze = 1; zt = 1; end
         4'h3: ml = 1;
         4'h5: ce = 1;
         4'h6: ct = 1;
         4'h7: rr = 1;
         4'h9: begin ce = 1; zt = 1; end
         4'hA: begin pr = 1; ac = 1; end
         4'hB: cr = 1;
         4'hC: begin ze = 1; zt = 1; zrr = 1; end
         4'hD: begin pr = 1; to = 1; end
         4'hE: begin pr = 1; er = 1; end
         default: ;
      endcase
      return {ze, ce, zr, cr, zt, ct, zrr, rr, ml, pr, ac, er, to};
   endfunction

   task automatic check(input string nm, input logic [3:0] c);
      logic [12:0] act;
      act = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR,
             mostraLeds, pronto, acertou, errou, timeout};
      n_tests++;
      if (db_estado !== c || act !== exp_out(c)) begin
         n_fail++;
         $display("FAIL %s @%0t: db_estado=%h outs=%b, expected db_estado=%h outs=%b",
                  nm, $time, db_estado, act, c, exp_out(c));
      end
   endtask

   // called at a negedge: drive {iniciar,jogada,igual,eir,fimRod,fimT}, clock once, check
   task automatic step(input logic [5:0] v, input logic [3:0] c, input string nm);
      {iniciar, jogada, igual, eir, fimRod, fimT} = v;
      @(posedge clock);
      @(negedge clock);
      check(nm, c);
   endtask

   typedef struct {
      logic [5:0] inp;
      logic [3:0] code;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic [5:0] i, input logic [3:0] c, input int n);
      vec_t v;
      v.inp  = i;
      v.code = c;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   // random-play model state
   logic [3:0] m_code, m_next;
   logic [3:0] disp_q[$];
   int addr, rod;

   initial begin
      logic [12:0] ctl;
      {iniciar, jogada, igual, eir, fimRod, fimT} = '0;
      reset = 1'b0;

      // game 1: round 0 won, round 1 lost by wrong move; game 2: timeout
      add(6'b100000, 4'h1, 1);
      add(6'b000000, 4'h2, 1);
      add(6'b000100, 4'h3, DISP);
      add(6'b000100, 4'h4, GAP);
      add(6'b000100, 4'hC, 1);
      add(6'b000100, 4'h6, 2);
      add(6'b011100, 4'h7, 1);
      add(6'b001100, 4'h8, 1);
      add(6'b001100, 4'hB, 1);
      add(6'b000000, 4'h2, 1);
      add(6'b000000, 4'h3, DISP);
      add(6'b000000, 4'h4, GAP);
      add(6'b000000, 4'h5, 1);
      add(6'b000000, 4'h3, DISP);
      add(6'b000100, 4'h4, GAP);
      add(6'b000100, 4'hC, 1);
      add(6'b000000, 4'h6, 1);
      add(6'b011000, 4'h7, 1);
      add(6'b001000, 4'h8, 1);
      add(6'b001000, 4'h9, 1);
      add(6'b000000, 4'h6, 1);
      add(6'b010001, 4'h7, 1);
      add(6'b000000, 4'h8, 1);
      add(6'b000100, 4'hE, 1);
      add(6'b010111, 4'hE, 1);
      add(6'b100000, 4'h1, 1);
      add(6'b000000, 4'h2, 1);
      add(6'b000100, 4'h3, DISP);
      add(6'b000100, 4'h4, GAP);
      add(6'b000100, 4'hC, 1);
      add(6'b000000, 4'h6, 1);
      add(6'b000001, 4'hD, 1);
      add(6'b011111, 4'hD, 1);
      add(6'b100000, 4'h1, 1);
      add(6'b000000, 4'h2, 1);

      repeat (2) @(negedge clock);
      check("reset_state", 4'h0);
      reset = 1'b1;

      foreach (vecs[i]) step(vecs[i].inp, vecs[i].code, $sformatf("vec%0d", i));

      // asynchronous reset in the middle of a lit step
      step(6'b000100, 4'h3, "pre_reset_mostra");
      #1 reset = 1'b0;
      #1 check("async_reset", 4'h0);
      @(posedge clock);
      @(negedge clock);
      check("reset_held", 4'h0);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) step(6'b010111, 4'h0, "idle_no_iniciar");

      // single-round win, held until iniciar
      step(6'b100000, 4'h1, "win_prep");
      step(6'b000000, 4'h2, "win_inicia");
      for (int k = 0; k < DISP; k++) step(6'b000110, 4'h3, "win_mostra");
      for (int k = 0; k < GAP; k++)  step(6'b000110, 4'h4, "win_intervalo");
      step(6'b000110, 4'hC, "win_zera_end");
      step(6'b000110, 4'h6, "win_espera");
      step(6'b011110, 4'h7, "win_registra");
      step(6'b001110, 4'h8, "win_compara");
      step(6'b001110, 4'hA, "win_acertou");
      step(6'b011111, 4'hA, "win_hold");
      step(6'b000001, 4'hA, "win_hold");
      step(6'b100000, 4'h1, "win_restart");

      // random play against the game-level model
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      m_code = 4'h0;
      addr = 0;
      rod = 0;
      disp_q.delete();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         check("random", m_code);
         iniciar = (m_code == 4'h0 || m_code == 4'hA || m_code == 4'hD || m_code == 4'hE)
                   ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         jogada  = (m_code == 4'h6) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 5) == 0);
         igual   = ($urandom_range(0, 7) != 0);
         fimT    = ($urandom_range(0, 9) == 0);
         eir     = (addr == rod);
         fimRod  = (rod == LAST_ROUND);

         if (m_code == 4'h2) begin
            // whole replay of round rod: lit/dark windows, advance between steps, rewind at end
            disp_q.delete();
            for (int k = 0; k <= rod; k++) begin
               for (int j = 0; j < DISP; j++) disp_q.push_back(4'h3);
               for (int j = 0; j < GAP; j++)  disp_q.push_back(4'h4);
               disp_q.push_back((k < rod) ? 4'h5 : 4'hC);
            end
         end
         if (disp_q.size() > 0) m_next = disp_q.pop_front();
         else begin
            case (m_code)
               4'h0:             m_next = iniciar ? 4'h1 : 4'h0;
               4'h1:             m_next = 4'h2;
               4'h6:             m_next = jogada ? 4'h7 : (fimT ? 4'hD : 4'h6);
               4'h7:             m_next = 4'h8;
               4'h8:             m_next = !igual ? 4'hE : (!eir ? 4'h9 : (fimRod ? 4'hA : 4'hB));
               4'h9, 4'hC:       m_next = 4'h6;
               4'hB:             m_next = 4'h2;
               4'hA, 4'hD, 4'hE: m_next = iniciar ? 4'h1 : m_code;
               default:          m_next = 4'h0;
            endcase
         end

         ctl = exp_out(m_code);
         if (ctl[12])      addr = 0;
         else if (ctl[11]) addr++;
         if (ctl[10])      rod = 0;
         else if (ctl[9])  rod++;

         @(posedge clock);
         @(negedge clock);
         m_code = m_next;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
